// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter sequencer.
//   - pc_state_e : FSM state encoding (BOOT / RUN / REDIRECT)
//   - PC_ADDR_W, PC_RESET_PC, PC_BUBBLES : default configuration shared with
//     PCControl and the fetch stage
//   - PC_BUB_W : width of the redirect bubble counter (BUBBLES is 1..15)
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2
  } pc_state_e;

  localparam int unsigned PC_ADDR_W   = 8;
  localparam int unsigned PC_RESET_PC = 0;
  localparam int unsigned PC_BUBBLES  = 2;
  localparam int unsigned PC_BUB_W    = 4;

endpackage

// File: rtl/pc_bubble_timer.sv
// pc_bubble_timer: loadable down-counter timing the post-redirect window.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : reload value
//   dec        : decrement by one this cycle
//   value      : current count
//   done       : value == 0
module pc_bubble_timer
  import pc_pkg::*;
#(
  parameter int unsigned CNT_W = PC_BUB_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    value <= '0;
    else if (load) value <= load_val;
    else if (dec)  value <= value - 1'b1;
  end

  assign done = (value == '0);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage fed by PCControl.
// Holds the architectural PC, issues instruction fetches, applies stalls and
// redirects, and opens a bubble window after each redirect during which the
// fetch address is marked invalid.
// Ports:
//   in_clk, in_rst_n : clock, async active-low reset
//   in_pc_sel        : 1 = load in_target (ignored in BOOT)
//   in_target        : branch/jump target
//   in_stall         : hold PC (redirect still wins)
//   in_imem_ready    : imem accepted the current request -> advance
//   out_pc           : current fetch address
//   out_imem_req     : fetch request (state != BOOT)
//   out_pc_valid     : fetch is not squashed (state == RUN)
//   out_flush        : one-cycle squash pulse on each accepted redirect
//   out_redirect_cnt : saturating count of accepted redirects, present only
//                      when PC_SEQUENCER_REDIRECT_COUNT_EN is defined
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W   = PC_ADDR_W,
  parameter int unsigned RESET_PC = PC_RESET_PC,
  parameter int unsigned PC_INC   = 1,
  parameter int unsigned BUBBLES  = PC_BUBBLES
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_pc_sel,
  input  logic [ADDR_W-1:0] in_target,
  input  logic              in_stall,
  input  logic              in_imem_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_imem_req,
  output logic              out_pc_valid,
`ifdef PC_SEQUENCER_REDIRECT_COUNT_EN
  output logic [15:0]       out_redirect_cnt,
`endif
  output logic              out_flush
);

  pc_state_e           state;
  logic [ADDR_W-1:0]   pc;
  logic                flush;
  logic                redirect;
  logic [PC_BUB_W-1:0] tmr_value;
  logic                tmr_done;

  // A redirect is only honoured once the sequencer has left BOOT.
  assign redirect = in_pc_sel && (state != ST_BOOT);

  // Counter is reloaded with BUBBLES-1 so that, counting the load cycle's
  // successor, REDIRECT lasts exactly BUBBLES cycles. Decrement stops at zero.
  pc_bubble_timer #(.CNT_W(PC_BUB_W)) u_timer (
    .clk      (in_clk),
    .rst_n    (in_rst_n),
    .load     (redirect),
    .load_val (PC_BUB_W'(BUBBLES - 1)),
    .dec      ((state == ST_REDIRECT) && (tmr_value != '0)),
    .value    (tmr_value),
    .done     (tmr_done)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= ST_BOOT;
      pc    <= ADDR_W'(RESET_PC);
      flush <= 1'b0;
    end else begin
      flush <= redirect;
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (in_pc_sel) begin
            pc    <= in_target;
            state <= ST_REDIRECT;
          end else if (!in_stall && in_imem_ready) begin
            pc <= pc + ADDR_W'(PC_INC);  // wraps modulo 2^ADDR_W
          end
        end
        ST_REDIRECT: begin
          // Newest target wins; the timer reload restarts the window.
          if (in_pc_sel)     pc    <= in_target;
          else if (tmr_done) state <= ST_RUN;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

`ifdef PC_SEQUENCER_REDIRECT_COUNT_EN
  logic [15:0] redirect_cnt;
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n)                             redirect_cnt <= '0;
    else if (redirect && redirect_cnt != '1)   redirect_cnt <= redirect_cnt + 16'd1;
  end
  assign out_redirect_cnt = redirect_cnt;
`endif

  assign out_pc       = pc;
  assign out_imem_req = (state != ST_BOOT);
  assign out_pc_valid = (state == ST_RUN);
  assign out_flush    = flush;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer (ADDR_W=8, RESET_PC=0,
// PC_INC=1, BUBBLES=2). The stimulus process pushes the expected outputs for
// the current cycle and drives inputs for the next edge; a monitor pops and
// compares on every falling edge.
module tb_pc_sequencer;

  typedef struct {
    logic [7:0] pc;
    logic       req;
    logic       vld;
    logic       flush;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pc_sel = 1'b0;
  logic [7:0] target = 8'h00;
  logic       stall = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] pc;
  logic       req, vld, flush;
`ifdef PC_SEQUENCER_REDIRECT_COUNT_EN
  logic [15:0] rcnt;
`endif

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   nid   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(8), .RESET_PC(0), .PC_INC(1), .BUBBLES(2)) dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_pc_sel     (pc_sel),
    .in_target     (target),
    .in_stall      (stall),
    .in_imem_ready (ready),
    .out_pc        (pc),
    .out_imem_req  (req),
    .out_pc_valid  (vld),
`ifdef PC_SEQUENCER_REDIRECT_COUNT_EN
    .out_redirect_cnt (rcnt),
`endif
    .out_flush     (flush)
  );

  // Monitor: one expected vector per falling edge when one is pending.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (pc !== e.pc || req !== e.req || vld !== e.vld || flush !== e.flush) begin
        fails++;
        $display("FAIL vec%0d: got pc=%h req=%b vld=%b flush=%b, want pc=%h req=%b vld=%b flush=%b",
                 e.id, pc, req, vld, flush, e.pc, e.req, e.vld, e.flush);
      end
    end
  end

  task automatic expect_now(input logic [7:0] p, input logic r, v, f);
    exp_t e;
    e.pc = p; e.req = r; e.vld = v; e.flush = f; e.id = nid++;
    q.push_back(e);
  endtask

  // Expect outputs after this edge, then set inputs for the following edge.
  task automatic step(input logic [7:0] p, input logic r, v, f,
                      input logic sel, input logic [7:0] tgt,
                      input logic st, input logic rdy);
    @(posedge clk); #1;
    expect_now(p, r, v, f);
    pc_sel = sel; target = tgt; stall = st; ready = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then BOOT cycle after release.
    #1 expect_now(8'h00, 0, 0, 0);
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1'b1;
    expect_now(8'h00, 0, 0, 0);
    // 1. Sequential fetch
    step(8'h00, 1, 1, 0, 0, 8'h00, 0, 1);
    step(8'h01, 1, 1, 0, 0, 8'h00, 0, 1);
    step(8'h02, 1, 1, 0, 0, 8'h00, 0, 1);
    step(8'h03, 1, 1, 0, 0, 8'h00, 0, 1);
    step(8'h04, 1, 1, 0, 0, 8'h00, 0, 1);
    // 2. Stall hold, then imem-not-ready hold
    step(8'h05, 1, 1, 0, 0, 8'h00, 1, 1);
    step(8'h05, 1, 1, 0, 0, 8'h00, 1, 1);
    step(8'h05, 1, 1, 0, 0, 8'h00, 1, 1);
    step(8'h05, 1, 1, 0, 0, 8'h00, 0, 0);
    step(8'h05, 1, 1, 0, 0, 8'h00, 0, 0);
    step(8'h05, 1, 1, 0, 0, 8'h00, 0, 0);
    step(8'h05, 1, 1, 0, 0, 8'h00, 0, 1);
    step(8'h06, 1, 1, 0, 0, 8'h00, 0, 1);
    // 3. Redirect with simultaneous stall
    step(8'h07, 1, 1, 0, 1, 8'h40, 1, 1);
    step(8'h40, 1, 0, 1, 0, 8'h00, 0, 1);
    step(8'h40, 1, 0, 0, 0, 8'h00, 0, 1);
    step(8'h40, 1, 1, 0, 0, 8'h00, 0, 1);
    step(8'h41, 1, 1, 0, 0, 8'h00, 0, 1);
    // 4. Wrap from 0xFF to 0x00
    step(8'h42, 1, 1, 0, 1, 8'hFE, 0, 1);
    step(8'hFE, 1, 0, 1, 0, 8'h00, 0, 1);
    step(8'hFE, 1, 0, 0, 0, 8'h00, 0, 1);
    step(8'hFE, 1, 1, 0, 0, 8'h00, 0, 1);
    step(8'hFF, 1, 1, 0, 0, 8'h00, 0, 1);
    step(8'h00, 1, 1, 0, 0, 8'h00, 0, 1);
    // 5. Redirect restarted in the second REDIRECT cycle
    step(8'h01, 1, 1, 0, 1, 8'h40, 0, 1);
    step(8'h40, 1, 0, 1, 0, 8'h00, 0, 1);
    step(8'h40, 1, 0, 0, 1, 8'h80, 0, 1);
    step(8'h80, 1, 0, 1, 0, 8'h00, 0, 1);
    step(8'h80, 1, 0, 0, 0, 8'h00, 0, 1);
    step(8'h80, 1, 1, 0, 0, 8'h00, 0, 1);
    step(8'h81, 1, 1, 0, 1, 8'h20, 0, 1);
    // 6. Async reset between edges while in REDIRECT
    @(posedge clk); #1;
    pc_sel = 1'b0; target = 8'h00;
    #2 rst_n = 1'b0;
    expect_now(8'h00, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_now(8'h00, 0, 0, 0);
    step(8'h00, 1, 1, 0, 0, 8'h00, 0, 1);
    step(8'h01, 1, 1, 0, 0, 8'h00, 0, 1);
    step(8'h02, 1, 1, 0, 0, 8'h00, 0, 1);
    @(posedge clk); @(negedge clk); #1;
`ifdef PC_SEQUENCER_REDIRECT_COUNT_EN
    // Cleared by the reset in test 6, no redirects since.
    tests++;
    if (rcnt !== 16'd0) begin
      fails++;
      $display("FAIL redirect_cnt: got %0d, want 0", rcnt);
    end
`endif
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
